// File: rtl/mem_access_unit.sv
// Load/store sequencer between datapath and data memory: drives address, write
// data and write-enable, extends loaded bytes/halves, and flags misalignment or timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        st,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [1:0]  mem_we,
    input  logic [31:0] mem_rd,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        st_q, st_nxt;
    logic [2:0]  op_q, op_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        err_q, err_nxt;
    logic [31:0] rdata_nxt, mem_a_nxt, mem_wd_nxt;
    logic        bad_req;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] wd_rep;

    // Alignment/legality is judged on the live request so a bad one never reaches REQ.
    always_comb begin
        unique case (op[1:0])
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = addr[0];
            2'b10:   bad_req = |addr[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        unique case (op[1:0])
            2'b00:   wd_rep = {4{wdata[7:0]}};
            2'b01:   wd_rep = {2{wdata[15:0]}};
            default: wd_rep = wdata;
        endcase
    end

    assign lane_b = mem_rd[{mem_a[1:0], 3'b000} +: 8];
    assign lane_h = mem_rd[{mem_a[1], 4'b0000} +: 16];

    always_comb begin
        unique case (op_q[1:0])
            2'b00:   load_val = op_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = op_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_rd;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        st_nxt     = st_q;
        op_nxt     = op_q;
        cnt_nxt    = cnt;
        err_nxt    = err_q;
        rdata_nxt  = rdata;
        mem_a_nxt  = mem_a;
        mem_wd_nxt = mem_wd;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (bad_req) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt  = REQ;
                        st_nxt     = st;
                        op_nxt     = op;
                        mem_a_nxt  = addr;
                        mem_wd_nxt = wd_rep;
                        cnt_nxt    = 8'd0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (!st_q) rdata_nxt = load_val;
                    state_nxt = DONE;
                    err_nxt   = 1'b0;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            st_q   <= 1'b0;
            op_q   <= 3'd0;
            cnt    <= 8'd0;
            err_q  <= 1'b0;
            rdata  <= 32'd0;
            mem_a  <= 32'd0;
            mem_wd <= 32'd0;
        end else begin
            state  <= state_nxt;
            st_q   <= st_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
            rdata  <= rdata_nxt;
            mem_a  <= mem_a_nxt;
            mem_wd <= mem_wd_nxt;
        end
    end

    // Write-enable decodes straight from state so an asynchronous reset drops it at once.
    always_comb begin
        mem_we = 2'b00;
        if (state == REQ && st_q) begin
            unique case (op_q[1:0])
                2'b00:   mem_we = 2'b11;
                2'b01:   mem_we = 2'b10;
                default: mem_we = 2'b01;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = done & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a small byte-lane memory model plus a
// scoreboard of expected completions checked when done pulses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, st, mem_ready;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic [1:0]  mem_we;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:63];
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .st(st), .op(op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (mem_ready) begin
            case (mem_we)
                2'b01: mem[mem_a[7:2]] <= mem_wd;
                2'b10: mem[mem_a[7:2]][{mem_a[1], 4'b0000} +: 16] <= mem_wd[{mem_a[1], 4'b0000} +: 16];
                2'b11: mem[mem_a[7:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[{mem_a[1:0], 3'b000} +: 8];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; poke pulses an extra start mid-wait that must be ignored.
    task automatic access(input string tag, input logic s, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                          input int exp_lat, input int exp_we_cycles, input logic [1:0] exp_we,
                          input logic [31:0] exp_wd, input logic exp_err,
                          input logic [31:0] exp_rdata, input bit poke);
        exp_t        e;
        int          lat, we_cycles, done_seen;
        logic [1:0]  we_seen;
        logic [31:0] wd_seen, a_seen;
        sb_q.push_back('{err: exp_err, rdata: exp_rdata});
        start = 1'b1; st = s; op = o; addr = a; wdata = wd; mem_ready = rdy;
        tick();
        start = 1'b0;
        lat = 1; we_cycles = 0; we_seen = 2'b00; wd_seen = 32'd0; a_seen = 32'd0;
        while (!done && lat < 64) begin
            if (mem_we != 2'b00) begin
                if (we_cycles == 0) begin
                    we_seen = mem_we; wd_seen = mem_wd; a_seen = mem_a;
                end
                we_cycles++;
            end
            if (poke && lat == 5) begin
                start = 1'b1; st = 1'b1; op = 3'b000; addr = 32'h30;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, {31'd0, done}, 32'd1);
        e = sb_q.pop_front();
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, {31'd0, err}, {31'd0, e.err});
        check({tag, " rdata"}, rdata, e.rdata);
        check({tag, " we_cycles"}, we_cycles, exp_we_cycles);
        if (exp_we_cycles != 0) begin
            check({tag, " mem_we"}, {30'd0, we_seen}, {30'd0, exp_we});
            check({tag, " mem_wd"}, wd_seen, exp_wd);
            check({tag, " mem_a"}, a_seen, a);
        end
        tick();
        done_seen = done;
        check({tag, " done_once"}, done_seen, 0);
        check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; st = 1'b0; op = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0;
        tick(); tick();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst mem_a", mem_a, 32'd0);
        check("rst mem_wd", mem_wd, 32'd0);
        check("rst mem_we", {30'd0, mem_we}, 32'd0);
        reset = 1'b0;
        tick();

        access("sw",   1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 2, 1, 2'b01, 32'hDEADBEEF, 0, 32'h0,        0);
        access("lw",   0, 3'b010, 32'h10, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'hDEADBEEF, 0);
        access("sw2",  1, 3'b010, 32'h10, 32'h80FF7F01, 1, 2, 1, 2'b01, 32'h80FF7F01, 0, 32'hDEADBEEF, 0);
        access("lb3",  0, 3'b000, 32'h13, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'hFFFFFF80, 0);
        access("lbu3", 0, 3'b100, 32'h13, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'h00000080, 0);
        access("lb0",  0, 3'b000, 32'h10, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'h00000001, 0);
        access("sh",   1, 3'b001, 32'h22, 32'h1234ABCD, 1, 2, 1, 2'b10, 32'hABCDABCD, 0, 32'h00000001, 0);
        access("lh",   0, 3'b001, 32'h22, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'hFFFFABCD, 0);
        access("lhu",  0, 3'b101, 32'h22, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'h0000ABCD, 0);
        access("lw20", 0, 3'b010, 32'h20, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'hABCD0000, 0);
        access("sb",   1, 3'b000, 32'h21, 32'h000000C3, 1, 2, 1, 2'b11, 32'hC3C3C3C3, 0, 32'hABCD0000, 0);
        access("lw21", 0, 3'b010, 32'h20, 32'h0,        1, 2, 0, 2'b00, 32'h0,        0, 32'hABCDC300, 0);

        access("mis lw", 0, 3'b010, 32'h06, 32'h0,        1, 1, 0, 2'b00, 32'h0, 1, 32'hABCDC300, 0);
        access("mis lh", 0, 3'b001, 32'h05, 32'h0,        1, 1, 0, 2'b00, 32'h0, 1, 32'hABCDC300, 0);
        access("ill sz", 1, 3'b011, 32'h10, 32'hFFFFFFFF, 1, 1, 0, 2'b00, 32'h0, 1, 32'hABCDC300, 0);

        access("tmo",  0, 3'b010, 32'h10, 32'h0, 0, 16, 0, 2'b00, 32'h0, 1, 32'hABCDC300, 1);
        access("post", 0, 3'b010, 32'h10, 32'h0, 1, 2,  0, 2'b00, 32'h0, 0, 32'h80FF7F01, 0);

        // Reset lands between edges while a store waits in REQ.
        start = 1'b1; st = 1'b1; op = 3'b010; addr = 32'h40; wdata = 32'h55AA55AA; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        check("rmid we_pre", {30'd0, mem_we}, 32'd1);
        check("rmid busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rmid we", {30'd0, mem_we}, 32'd0);
        check("rmid busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(done);
            tick();
        end
        check("rmid no_done", pulses, 0);
        check("sb empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
